axi_native_bridge: RTL and testbench

AXI4-subset slave that converts the burst traffic of `axi_self_test_master` into single-beat native memory requests for the DDR controller user port. It sits directly downstream of the self-test master and upstream of the DDR controller. It serialises one write or read burst at a time, expands each burst into per-beat addresses, and buffers read data in a small FIFO so R-channel backpressure never stalls the controller's read return.

---
 rtl/axi_native_bridge_if.sv | 59 +++++
 rtl/axi_native_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_axi_native_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_native_bridge_if.sv
// AXI4-subset slave channels plus native memory request/return port.
// The slave modport is the bridge view; master drives the i_* side.
interface axi_native_bridge_if #(
    parameter int AW = 26,
    parameter int DW = 16
);
    logic          i_awvalid;
    logic          o_awready;
    logic [AW-1:0] i_awaddr;
    logic [7:0]    i_awlen;
    logic          i_wvalid;
    logic          o_wready;
    logic          i_wlast;
    logic [DW-1:0] i_wdata;
    logic          o_bvalid;
    logic          i_bready;
    logic          i_arvalid;
    logic          o_arready;
    logic [AW-1:0] i_araddr;
    logic [7:0]    i_arlen;
    logic          o_rvalid;
    logic          i_rready;
    logic          o_rlast;
    logic [DW-1:0] o_rdata;
    logic          o_mem_req;
    logic          i_mem_ack;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;
    logic          o_wlast_err;

    modport slave (
        input  i_awvalid, i_awaddr, i_awlen,
        input  i_wvalid, i_wlast, i_wdata,
        input  i_bready,
        input  i_arvalid, i_araddr, i_arlen,
        input  i_rready,
        input  i_mem_ack, i_mem_rvalid, i_mem_rdata,
        output o_awready, o_wready, o_bvalid,
        output o_arready, o_rvalid, o_rlast, o_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_wlast_err
    );

    modport master (
        output i_awvalid, i_awaddr, i_awlen,
        output i_wvalid, i_wlast, i_wdata,
        output i_bready,
        output i_arvalid, i_araddr, i_arlen,
        output i_rready,
        output i_mem_ack, i_mem_rvalid, i_mem_rdata,
        input  o_awready, o_wready, o_bvalid,
        input  o_arready, o_rvalid, o_rlast, o_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_wlast_err
    );
endinterface

// File: rtl/axi_native_bridge.sv
// Burst-to-single-beat bridge: AXI4-subset slave in, native memory port out.
// Define AXI_NATIVE_BRIDGE_RR_ARB_EN for round-robin AW/AR arbitration.
module axi_native_bridge #(
    parameter int AW          = 26,
    parameter int DW          = 16,
    parameter int D_LEVEL     = 1,
    parameter int RFIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_native_bridge_if.slave   bus
);
    localparam int PW = $clog2(RFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] STEP = {{(AW-1){1'b0}}, 1'b1} << D_LEVEL;
    localparam logic [CW:0]   DEPTH = (CW+1)'(RFIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_W, S_B, S_R} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [DW:0]   mem_q [RFIFO_DEPTH];
    logic [DW:0]   mem_d [RFIFO_DEPTH];

    logic          wgnt, rgnt;
    logic          aw_go, ar_go;
    logic          rvalid, pop, push;
    logic          credit, rd_req, rack;
    logic          wbeat, wl_hit;
    logic [DW:0]   head;

`ifdef AXI_NATIVE_BRIDGE_RR_ARB_EN
    logic last_rd_q, last_rd_d;

    // Round-robin grant: on a tie the type not served last wins
    always_comb begin
        wgnt      = bus.i_awvalid;
        rgnt      = bus.i_arvalid;
        if (bus.i_awvalid && bus.i_arvalid) begin
            wgnt = last_rd_q;
            rgnt = !last_rd_q;
        end
        last_rd_d = last_rd_q;
        if (state_q == S_IDLE && rst_n) begin
            if (wgnt)
                last_rd_d = 1'b0;
            else if (rgnt)
                last_rd_d = 1'b1;
        end
    end

    // Last-served burst type; write counts as served after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_rd_q <= 1'b0;
        else
            last_rd_q <= last_rd_d;
    end
`else
    // Fixed grant: write wins a tie
    always_comb begin
        wgnt = bus.i_awvalid;
        rgnt = bus.i_arvalid && !bus.i_awvalid;
    end
`endif

    assign aw_go  = rst_n && wgnt;
    assign ar_go  = rst_n && rgnt;
    assign head   = mem_q[rptr_q];
    assign rvalid = (fcnt_q != '0);
    assign pop    = rvalid && bus.i_rready;
    assign push   = bus.i_mem_rvalid && (out_q != '0);
    assign credit = ({1'b0, fcnt_q} + {1'b0, out_q}) < DEPTH;
    assign rd_req = (state_q == S_R) && (cnt_q <= {1'b0, len_q})
                    && credit;
    assign rack   = rd_req && bus.i_mem_ack;
    assign wbeat  = (state_q == S_W) && bus.i_wvalid && bus.i_mem_ack;
    assign wl_hit = (cnt_q[7:0] == len_q);

    // Burst FSM next state, beat address/counters and port outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        err_d    = err_q;

        bus.o_awready   = 1'b0;
        bus.o_arready   = 1'b0;
        bus.o_wready    = 1'b0;
        bus.o_bvalid    = 1'b0;
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_wlast_err = err_q;
        bus.o_rvalid    = rvalid;
        bus.o_rlast     = rvalid && head[DW];
        bus.o_rdata     = rvalid ? head[DW-1:0] : '0;

        unique case (state_q)
            S_IDLE: begin
                bus.o_awready = aw_go;
                bus.o_arready = ar_go;
                if (aw_go) begin
                    addr_d  = bus.i_awaddr;
                    len_d   = bus.i_awlen;
                    cnt_d   = '0;
                    state_d = S_W;
                end else if (ar_go) begin
                    addr_d  = bus.i_araddr;
                    len_d   = bus.i_arlen;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    state_d = S_R;
                end
            end
            S_W: begin
                bus.o_mem_req   = bus.i_wvalid;
                bus.o_mem_we    = 1'b1;
                bus.o_mem_wdata = bus.i_wdata;
                bus.o_mem_addr  = addr_q;
                bus.o_wready    = bus.i_mem_ack;
                if (wbeat) begin
                    addr_d = addr_q + STEP;
                    cnt_d  = cnt_q + 9'd1;
                    if (wl_hit != bus.i_wlast)
                        err_d = 1'b1;
                    if (wl_hit)
                        state_d = S_B;
                end
            end
            S_B: begin
                bus.o_bvalid = 1'b1;
                if (bus.i_bready)
                    state_d = S_IDLE;
            end
            S_R: begin
                bus.o_mem_req  = rd_req;
                bus.o_mem_addr = addr_q;
                if (rack) begin
                    addr_d = addr_q + STEP;
                    cnt_d  = cnt_q + 9'd1;
                end
                if (push)
                    rcnt_d = rcnt_q + 8'd1;
                if (pop && head[DW])
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-return FIFO and outstanding-request credit tracking
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        out_d  = out_q;
        if (push) begin
            mem_d[wptr_q] = {(rcnt_q == len_q), bus.i_mem_rdata};
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop)
            rptr_d = rptr_q + 1'b1;
        if (push && !pop)
            fcnt_d = fcnt_q + 1'b1;
        else if (pop && !push)
            fcnt_d = fcnt_q - 1'b1;
        if (rack && !push)
            out_d = out_q + 1'b1;
        else if (push && !rack)
            out_d = out_q - 1'b1;
    end

    // State, burst context and FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
            fcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < RFIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
            out_q   <= out_d;
            fcnt_q  <= fcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_axi_native_bridge.sv
// Directed bench for axi_native_bridge with a latency-programmable
// native memory responder.
module tb_axi_native_bridge;
    localparam int AW = 26;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_native_bridge_if #(.AW(AW), .DW(DW)) bus ();

    axi_native_bridge #(
        .AW(AW), .DW(DW), .D_LEVEL(1), .RFIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int ncmp = 0;
    int nfail = 0;
    int rd_lat = 2;
    int cyc = 0;
    int rd_acks = 0;
    int base;
    logic [AW-1:0] pa[$];
    int            pd[$];
    logic [AW-1:0] alog[$];
    logic [AW-1:0] exp_a [4];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Memory model: read data returns rd_lat cycles after the ack cycle
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.o_mem_req && bus.i_mem_ack && !bus.o_mem_we) begin
            pa.push_back(bus.o_mem_addr);
            pd.push_back(cyc + rd_lat - 1);
            alog.push_back(bus.o_mem_addr);
            rd_acks = rd_acks + 1;
        end
        if (pa.size() != 0 && pd[0] <= cyc) begin
            bus.i_mem_rvalid <= 1'b1;
            bus.i_mem_rdata  <= mdata(pa.pop_front());
            void'(pd.pop_front());
        end else begin
            bus.i_mem_rvalid <= 1'b0;
            bus.i_mem_rdata  <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_collect(input int n, input logic [AW-1:0] b,
                              input int maxc);
        int k = 0;
        int c = 0;
        logic [AW-1:0] a;
        while (k < n && c < maxc) begin
            if (bus.o_rvalid && bus.i_rready) begin
                a = b + AW'(2 * k);
                chk("r_data", 32'(bus.o_rdata), 32'(mdata(a)));
                chk("r_last", 32'(bus.o_rlast), 32'(k == n - 1));
                k++;
            end
            tick();
            #1;
            c++;
        end
        chk("r_beats", k, n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = '0;
        bus.i_awlen   = '0;
        bus.i_wvalid  = 1'b0;
        bus.i_wlast   = 1'b0;
        bus.i_wdata   = '0;
        bus.i_bready  = 1'b0;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = '0;
        bus.i_arlen   = '0;
        bus.i_rready  = 1'b0;
        bus.i_mem_ack = 1'b1;
        exp_a = '{26'h3FFFFFE, 26'h0, 26'h2, 26'h4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 32'(bus.o_awready), 0);
        chk("rst_arready", 32'(bus.o_arready), 0);
        chk("rst_wready", 32'(bus.o_wready), 0);
        chk("rst_bvalid", 32'(bus.o_bvalid), 0);
        chk("rst_rvalid", 32'(bus.o_rvalid), 0);
        chk("rst_rlast", 32'(bus.o_rlast), 0);
        chk("rst_rdata", 32'(bus.o_rdata), 0);
        chk("rst_req", 32'(bus.o_mem_req), 0);
        chk("rst_we", 32'(bus.o_mem_we), 0);
        chk("rst_addr", 32'(bus.o_mem_addr), 0);
        chk("rst_wdata", 32'(bus.o_mem_wdata), 0);
        chk("rst_err", 32'(bus.o_wlast_err), 0);
        bus.i_awvalid = 1'b0;
        bus.i_arvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_req", 32'(bus.o_mem_req), 0);

        // write burst 0x100 len 7
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 26'h100;
        bus.i_awlen   = 8'd7;
        #1;
        chk("w1_awready", 32'(bus.o_awready), 1);
        chk("w1_arready", 32'(bus.o_arready), 0);
        tick();
        bus.i_awvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = 16'hC000 + 16'(i);
            bus.i_wlast  = (i == 7);
            #1;
            chk("w1_req", 32'(bus.o_mem_req), 1);
            chk("w1_we", 32'(bus.o_mem_we), 1);
            chk("w1_addr", 32'(bus.o_mem_addr), 32'h100 + 32'(2 * i));
            chk("w1_wdata", 32'(bus.o_mem_wdata), 32'hC000 + 32'(i));
            chk("w1_wready", 32'(bus.o_wready), 1);
            chk("w1_bvalid_early", 32'(bus.o_bvalid), 0);
            tick();
        end
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        #1;
        chk("w1_bvalid", 32'(bus.o_bvalid), 1);
        chk("w1_req_off", 32'(bus.o_mem_req), 0);
        chk("w1_err", 32'(bus.o_wlast_err), 0);
        bus.i_bready = 1'b1;
        tick();
        bus.i_bready = 1'b0;
        #1;
        chk("w1_bvalid_off", 32'(bus.o_bvalid), 0);

        // simultaneous AW/AR: write first, read on the next idle cycle
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 26'h40;
        bus.i_awlen   = 8'd0;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 26'h80;
        bus.i_arlen   = 8'd0;
        #1;
        chk("arb_awready", 32'(bus.o_awready), 1);
        chk("arb_arready", 32'(bus.o_arready), 0);
        tick();
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b1;
        bus.i_wdata   = 16'hBEEF;
        bus.i_wlast   = 1'b1;
        #1;
        chk("arb_waddr", 32'(bus.o_mem_addr), 32'h40);
        tick();
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        #1;
        chk("arb_bvalid", 32'(bus.o_bvalid), 1);
        chk("arb_arready_b", 32'(bus.o_arready), 0);
        bus.i_bready = 1'b1;
        tick();
        bus.i_bready = 1'b0;
        #1;
        chk("arb_turnaround", 32'(bus.o_arready), 1);
        tick();
        bus.i_arvalid = 1'b0;
        bus.i_rready  = 1'b1;
        #1;
        chk("arb_rreq", 32'(bus.o_mem_req), 1);
        chk("arb_raddr", 32'(bus.o_mem_addr), 32'h80);
        chk("arb_rwe", 32'(bus.o_mem_we), 0);
        rd_collect(1, 26'h80, 20);

        // read with address wrap
        alog.delete();
        rd_lat = 2;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 26'h3FFFFFE;
        bus.i_arlen   = 8'd3;
        #1;
        chk("wrap_arready", 32'(bus.o_arready), 1);
        tick();
        bus.i_arvalid = 1'b0;
        #1;
        chk("wrap_first_addr", 32'(bus.o_mem_addr), 32'h3FFFFFE);
        rd_collect(4, 26'h3FFFFFE, 40);
        chk("wrap_nreq", alog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", 32'(alog[i]), 32'(exp_a[i]));

        // long read with R backpressure
        alog.delete();
        base = rd_acks;
        bus.i_rready  = 1'b0;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 26'h200;
        bus.i_arlen   = 8'd15;
        tick();
        bus.i_arvalid = 1'b0;
        repeat (20) tick();
        chk("stall_nreq", rd_acks - base, 4);
        chk("stall_req", 32'(bus.o_mem_req), 0);
        chk("stall_rvalid", 32'(bus.o_rvalid), 1);
        bus.i_rready = 1'b1;
        #1;
        rd_collect(16, 26'h200, 200);
        chk("stall_total", alog.size(), 16);

        // wlast on the wrong beat
        chk("err_pre", 32'(bus.o_wlast_err), 0);
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 26'h500;
        bus.i_awlen   = 8'd3;
        tick();
        bus.i_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = 16'(i);
            bus.i_wlast  = (i == 2);
            #1;
            chk("err_addr", 32'(bus.o_mem_addr), 32'h500 + 32'(2 * i));
            chk("err_flag", 32'(bus.o_wlast_err), 32'(i > 2));
            tick();
        end
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        #1;
        chk("err_bvalid", 32'(bus.o_bvalid), 1);
        chk("err_flag_end", 32'(bus.o_wlast_err), 1);
        bus.i_bready = 1'b1;
        tick();
        bus.i_bready = 1'b0;
        #1;
        chk("err_sticky", 32'(bus.o_wlast_err), 1);

        // reset with two reads outstanding, late returns ignored
        rd_lat = 6;
        base = rd_acks;
        bus.i_rready  = 1'b0;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 26'h600;
        bus.i_arlen   = 8'd7;
        tick();
        bus.i_arvalid = 1'b0;
        tick();
        tick();
        chk("rr_outstanding", rd_acks - base, 2);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr_rvalid", 32'(bus.o_rvalid), 0);
        end
        chk("rr_req", 32'(bus.o_mem_req), 0);
        chk("rr_err", 32'(bus.o_wlast_err), 0);
        rd_lat = 1;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 26'h700;
        bus.i_arlen   = 8'd1;
        #1;
        chk("rr_idle", 32'(bus.o_arready), 1);
        tick();
        bus.i_arvalid = 1'b0;
        bus.i_rready  = 1'b1;
        #1;
        rd_collect(2, 26'h700, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
